// File: rtl/if_stage.sv
// Instruction-fetch stage: fetches the word at pc over a req/gnt/rvalid port,
// hands it to decode with valid/ready, and owns all PC advancement via next_pc.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN_B  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic              req_q, valid_q, misalign_q;
  logic [XLEN-1:0]   instr_q, instr_pc_q;
  logic              capture;

  assign imem_addr   = pc;
  assign imem_req    = req_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;

  // Next-state, kill tracking and next_pc selection; redirect overrides last.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    capture = 1'b0;
    next_pc = pc;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          next_pc = pc + XLEN'(ILEN_B);
          state_d = S_REQ;
        end else if (redirect_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect_valid) begin
      next_pc = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      req_q      <= (state_d == S_REQ);
      valid_q    <= (state_d == S_HOLD);
      misalign_q <= redirect_valid & (|redirect_pc[1:0]);
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= pc;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: external PC register, programmable-latency
// instruction memory (word = addr ^ 32'h1357_9BDF) and a delivery monitor.
module tb_if_stage;

  logic        clk;
  logic        rstn;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        misalign;

  int n_chk = 0;
  int n_bad = 0;

  int gnt_wait = 0;
  int rv_wait  = 1;
  int rdy_wait = 0;
  int req_cnt, wait_cnt, hold_cnt;
  logic        pending;
  logic [31:0] paddr;

  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn), .pc(pc), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .misalign(misalign)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // PC register: loads next_pc every edge, resets with the shared rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= 32'h0;
    else       pc <= next_pc;
  end

  always @(posedge clk) begin
    if (rstn && instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_ins.push_back(instr);
    end
  end

  // Memory and decode-side responder, driven on the falling edge.
  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    pending = 1'b0; paddr = 32'h0; req_cnt = 0; wait_cnt = 0; hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
        pending = 1'b0; req_cnt = 0; wait_cnt = 0; hold_cnt = 0;
      end else begin
        imem_rvalid = 1'b0;
        if (pending) begin
          wait_cnt++;
          if (wait_cnt >= rv_wait) begin
            imem_rvalid = 1'b1;
            imem_rdata  = paddr ^ 32'h1357_9BDF;
            pending     = 1'b0;
          end
        end
        imem_gnt = 1'b0;
        if (imem_req && !pending) begin
          if (req_cnt >= gnt_wait) begin
            imem_gnt = 1'b1; pending = 1'b1; paddr = imem_addr;
            wait_cnt = 0; req_cnt = 0;
          end else begin
            req_cnt++;
          end
        end
        instr_ready = 1'b0;
        if (instr_valid) begin
          if (hold_cnt >= rdy_wait) instr_ready = 1'b1;
          hold_cnt++;
        end else begin
          hold_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int g, input int r, input int d);
    rstn = 1'b0;
    cyc();
    cyc();
    gnt_wait = g; rv_wait = r; rdy_wait = d;
    rstn = 1'b1;
    got_pc.delete();
    got_ins.delete();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #1;
  endtask

  logic found;

  initial begin
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #20;
    chk("rst_req",      32'(imem_req),    32'h0);
    chk("rst_valid",    32'(instr_valid), 32'h0);
    chk("rst_misalign", 32'(misalign),    32'h0);
    chk("rst_instr",    instr,            32'h0);
    chk("rst_instr_pc", instr_pc,         32'h0);
    chk("rst_next_pc",  next_pc,          32'h0);
    chk("rst_addr",     imem_addr,        32'h0);

    // Back-to-back fetch, one instruction per three cycles.
    #25;
    rstn = 1'b1;
    #1;
    chk("s1_idle_req", 32'(imem_req), 32'h0);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      chk("s1_next_pc", next_pc, 32'(4 * (k / 3)));
      if (k == 1)  chk("s1_first_req", 32'(imem_req), 32'h1);
      if (k == 12) chk("s1_instr_pc12", instr_pc, 32'hC);
    end
    chk("s1_count", 32'(got_pc.size()), 32'd4);
    chk("s1_pc0", got_pc[0], 32'h0);
    chk("s1_pc1", got_pc[1], 32'h4);
    chk("s1_pc2", got_pc[2], 32'h8);
    chk("s1_pc3", got_pc[3], 32'hC);
    chk("s1_ins1", got_ins[1], 32'h1357_9BDB);
    chk("s1_ins3", got_ins[3], 32'h1357_9BD3);

    // Slow grant, slow data, decode stalls four cycles.
    do_reset(3, 2, 4);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("s2_next_pc", next_pc, (k >= 11) ? 32'h4 : 32'h0);
      if (k <= 4) chk("s2_req_held", 32'(imem_req), 32'h1);
      if (k >= 7 && k <= 11) begin
        chk("s2_valid", 32'(instr_valid), 32'h1);
        chk("s2_instr", instr, 32'h1357_9BDF);
      end
    end
    chk("s2_valid_drop", 32'(instr_valid), 32'h0);
    chk("s2_count", 32'(got_pc.size()), 32'd1);
    chk("s2_pc", pc, 32'h4);

    // Redirect during WAIT: returning word is discarded.
    do_reset(0, 2, 0);
    cyc();
    cyc();
    redirect(32'h0000_0100);
    chk("s3_next_pc", next_pc, 32'h100);
    cyc();
    redirect_valid = 1'b0;
    chk("s3_no_valid", 32'(instr_valid), 32'h0);
    chk("s3_no_req",   32'(imem_req),    32'h0);
    cyc();
    chk("s3_req",  32'(imem_req), 32'h1);
    chk("s3_addr", imem_addr,     32'h100);
    cyc();
    chk("s3_no_valid2", 32'(instr_valid), 32'h0);
    cyc();
    cyc();
    chk("s3_valid",    32'(instr_valid), 32'h1);
    chk("s3_instr_pc", instr_pc,         32'h100);
    chk("s3_instr",    instr,            32'h1357_9ADF);
    cyc();
    chk("s3_count", 32'(got_pc.size()), 32'd1);
    chk("s3_got_pc", got_pc[0], 32'h100);

    // Redirect in HOLD, with and without instr_ready.
    do_reset(0, 1, 0);
    cyc();
    cyc();
    cyc();
    chk("s4_valid", 32'(instr_valid), 32'h1);
    redirect(32'h0000_0040);
    chk("s4_next_pc", next_pc, 32'h40);
    cyc();
    redirect_valid = 1'b0;
    chk("s4_count1", 32'(got_pc.size()), 32'd1);
    chk("s4_got_pc", got_pc[0], 32'h0);
    chk("s4_pc", pc, 32'h40);
    cyc();
    cyc();
    chk("s4_instr_pc", instr_pc, 32'h40);
    chk("s4_instr",    instr,    32'h1357_9B9F);
    rdy_wait = 100;
    cyc();
    cyc();
    cyc();
    chk("s4b_valid",    32'(instr_valid), 32'h1);
    chk("s4b_instr_pc", instr_pc,         32'h44);
    redirect(32'h0000_0040);
    chk("s4b_next_pc", next_pc, 32'h40);
    cyc();
    redirect_valid = 1'b0;
    chk("s4b_dropped", 32'(instr_valid), 32'h0);
    chk("s4b_count",   32'(got_pc.size()), 32'd2);
    chk("s4b_addr",    imem_addr, 32'h40);
    cyc();
    cyc();
    chk("s4b_refetch_valid", 32'(instr_valid), 32'h1);
    chk("s4b_refetch_pc",    instr_pc,         32'h40);

    // Misaligned redirect, then PC wrap at the top of memory.
    do_reset(5, 1, 0);
    cyc();
    redirect(32'h0000_0102);
    chk("s5_align", next_pc, 32'h100);
    cyc();
    redirect_valid = 1'b0;
    chk("s5_misalign_on", 32'(misalign), 32'h1);
    chk("s5_pc", pc, 32'h100);
    cyc();
    chk("s5_misalign_off", 32'(misalign), 32'h0);
    redirect(32'hFFFF_FFFC);
    chk("s5_top_next_pc", next_pc, 32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
    chk("s5_top_pc", pc, 32'hFFFF_FFFC);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("s5_wrap_next_pc", next_pc,  32'h0);
    chk("s5_wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("s5_wrap_instr",   instr,    32'hECA8_6423);
    cyc();
    chk("s5_wrap_pc", pc, 32'h0);
    chk("s5_wrap_got", got_pc[0], 32'hFFFF_FFFC);

    // Reset while a fetch is outstanding.
    gnt_wait = 0;
    rv_wait  = 3;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (pending && !imem_req) found = 1'b1;
    end
    chk("s6_reach_wait", 32'(found), 32'h1);
    rstn = 1'b0;
    #1;
    chk("s6_req",      32'(imem_req),    32'h0);
    chk("s6_valid",    32'(instr_valid), 32'h0);
    chk("s6_instr",    instr,            32'h0);
    chk("s6_instr_pc", instr_pc,         32'h0);
    chk("s6_next_pc",  next_pc,          32'h0);
    cyc();
    cyc();
    gnt_wait = 0; rv_wait = 1; rdy_wait = 0;
    rstn = 1'b1;
    got_pc.delete();
    got_ins.delete();
    cyc();
    chk("s6_no_stale1", 32'(instr_valid), 32'h0);
    cyc();
    chk("s6_no_stale2", 32'(instr_valid), 32'h0);
    cyc();
    chk("s6_valid_new", 32'(instr_valid), 32'h1);
    chk("s6_instr_new", instr,            32'h1357_9BDF);
    cyc();
    chk("s6_count", 32'(got_pc.size()), 32'd1);
    chk("s6_got_pc", got_pc[0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
